// File: rtl/alu_op_sequencer.sv
// ALU front-end: accepts one request at a time, issues single-cycle ops in one
// edge and runs multiply/divide as DATA_W-step shift-add / restoring sequences.
module alu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic               busy,
  output logic               res_valid,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_DIV = 6'b011010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_XOR = 6'b100110;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DIV} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SLL, OP_SRL,
    OP_OR, OP_AND, OP_NOR, OP_XOR, OP_ILL
  } op_t;

  state_t               state, state_next;
  op_t                  dec_op, op_q;
  logic [DATA_W-1:0]    op_a, op_b, acc;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [CNT_W-1:0]     cnt;

  logic [DATA_W-1:0]    exec_result;
  logic                 exec_err;
  logic [DATA_W:0]      rem_shift, rem_diff;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    dec_op = OP_ILL;
    case (alu_op)
      2'b00:   dec_op = OP_ADD;
      2'b01:   dec_op = OP_SUB;
      default: begin
        case (funct)
          F_ADD:   dec_op = OP_ADD;
          F_SUB:   dec_op = OP_SUB;
          F_MUL:   dec_op = OP_MUL;
          F_DIV:   dec_op = OP_DIV;
          F_SLL:   dec_op = OP_SLL;
          F_SRL:   dec_op = OP_SRL;
          F_OR:    dec_op = OP_OR;
          F_AND:   dec_op = OP_AND;
          F_NOR:   dec_op = OP_NOR;
          F_XOR:   dec_op = OP_XOR;
          default: dec_op = OP_ILL;
        endcase
      end
    endcase
  end

  // Multiply/divide fall through EXEC after their last step so completion
  // (result/zero/err/res_valid) is registered in exactly one place.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (dec_op == OP_MUL)                    state_next = MUL;
          else if (dec_op == OP_DIV && b != '0)    state_next = DIV;
          else                                     state_next = EXEC;
        end
      end
      EXEC:     state_next = IDLE;
      MUL, DIV: if (cnt == LAST_STEP) state_next = EXEC;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    exec_result = '0;
    exec_err    = 1'b0;
    case (op_q)
      OP_ADD: exec_result = op_a + op_b;
      OP_SUB: exec_result = op_a - op_b;
      OP_MUL: exec_result = acc;
      OP_DIV: begin
        if (op_b == '0) begin
          exec_result = '1;
          exec_err    = 1'b1;
        end else begin
          exec_result = op_a;
        end
      end
      OP_SLL: exec_result = op_a << shamt_q;
      OP_SRL: exec_result = op_a >> shamt_q;
      OP_OR:  exec_result = op_a | op_b;
      OP_AND: exec_result = op_a & op_b;
      OP_NOR: exec_result = ~(op_a | op_b);
      OP_XOR: exec_result = op_a ^ op_b;
      default: begin
        exec_result = '0;
        exec_err    = 1'b1;
      end
    endcase
  end

  // Restoring divide step: op_a shifts the dividend out and the quotient in, acc is the partial remainder.
  assign rem_shift = {acc, op_a[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, op_b};

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: operand/working registers are plain flops, not a memory, so they are reset like the rest of the state.
      state     <= IDLE;
      op_q      <= OP_ADD;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      shamt_q   <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_next;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a    <= a;
            op_b    <= b;
            shamt_q <= shamt;
            op_q    <= dec_op;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        MUL: begin
          if (op_b[0]) acc <= acc + op_a;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          if (cnt != LAST_STEP) cnt <= cnt + 1'b1;
        end
        DIV: begin
          op_a <= {op_a[DATA_W-2:0], ~rem_diff[DATA_W]};
          acc  <= rem_diff[DATA_W] ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
          if (cnt != LAST_STEP) cnt <= cnt + 1'b1;
        end
        EXEC: begin
          result    <= exec_result;
          zero      <= (exec_result == '0);
          err       <= exec_err;
          res_valid <= 1'b1;
          cnt       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Front-end controller for the processor's ALU datapath. It accepts one operation request at a time through a valid/ready handshake and decodes ALUOp/funct. Single-cycle operations are issued in one cycle. Multiply and divide run as 32-step iterative shift-add and restoring-divide sequences, with busy used as the stall signal to the rest of the datapath. It produces a registered result, a zero flag and an error flag with a one-cycle res_valid pulse.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W
SHAMT_W, 5, shift-amount width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid&&req_ready
alu_op  input  2  00 add, 01 sub, 10/11 decode funct
funct  input  6  function code (used when alu_op[1]=1)
shamt  input  SHAMT_W  shift amount
a  input  DATA_W  operand A
b  input  DATA_W  operand B
busy  output  1  state != IDLE (combinational from state reg)
res_valid  output  1  one-cycle pulse, result/zero/err valid
result  output  DATA_W  registered result, held until next completion
zero  output  1  registered, 1 iff result==0
err  output  1  registered, illegal funct or divide-by-zero

Behaviour:
- States: IDLE, EXEC, MUL, DIV. req_ready = (state==IDLE).
- Reset values: state IDLE, result 0, zero 0, err 0, res_valid 0, iteration counter 0, operand registers 0.
- Reset asserted mid-operation aborts the operation. No res_valid is produced. The block is IDLE with req_ready=1 in the cycle after reset deasserts.
- Accept edge E0: a, b, shamt and the decoded op are captured. Later input changes are ignored until the next acceptance. req_valid while not IDLE is ignored.
- Decode when alu_op=1x:
  - 100000 add, 100010 sub
  - 011000 mul, 011010 div
  - 000000 sll (a<<shamt), 000010 srl (a>>shamt, logical)
  - 100101 or, 100100 and, 100111 nor, 100110 xor (a^b)
  - any other code is illegal.
- Single-cycle ops, illegal funct and div with b==0 go to EXEC. At edge E1 the block registers result, zero and err, sets res_valid=1 and returns to IDLE. Latency is 1 edge. Maximum throughput is one op per 2 cycles.
- Illegal funct: result=0, zero=1, err=1.
- Divide by zero: result=all-ones, zero=0, err=1.
- MUL: unsigned shift-add, one multiplier bit per edge, for edges E1..E32. Result is the low DATA_W bits of the product, registered at E33 with res_valid=1 and return to IDLE.
- DIV (b!=0): unsigned restoring division, one quotient bit per edge, for edges E1..E32. The quotient is registered at E33. The remainder is discarded.
- Add/sub/mul wrap modulo 2^DATA_W. No overflow flag.
- err=0 on all legal completions. result, zero and err hold their values until the next completion.
- res_valid is high exactly one cycle, the first IDLE cycle after completion. A new request may be accepted in that same cycle.
- Counter: counts 0..31 in MUL/DIV. The op completes when the counter reaches 31 and the final step executes. The counter clears on return to IDLE.

Test Plan:
1. Reset, then alu_op=00, a=5, b=7 accepted at E0 -> res_valid=1 after E1 only, result=12, zero=0, err=0, req_ready=0 during EXEC.
2. alu_op=01, a=9, b=9 -> result=0, zero=1. Then funct=000000, a=1, shamt=31 -> result=0x8000_0000.
3. funct=011000, a=0x0001_0003, b=5 -> result=0x0005_000F. res_valid appears exactly 33 edges after acceptance. busy=1 and req_ready=0 throughout. Inputs toggled mid-op have no effect.
4. funct=011010, a=100, b=7 -> result=14 at 33 edges. Then a=5, b=0 -> result=0xFFFF_FFFF, err=1, res_valid after 1 edge.
5. Start div a=1000, b=3, assert reset at 10th iteration edge -> no res_valid, result=0, req_ready=1 the cycle after reset drops. A following add 2+2 completes normally with result 4.
6. funct=111111 -> result=0, zero=1, err=1. Back-to-back: a new request accepted in the res_valid cycle completes correctly with err=0.
